// File: rtl/adc_sample_packer_64.sv
// Frames 8ch x 16-bit ADC samples into fixed-length 64-bit AXI4-Stream packets:
// one header beat, then lo/hi beats per sample, behind a 2-entry sample buffer.
module adc_sample_packer_64 #(
  parameter int          DATA_WIDTH      = 64,
  parameter int          KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int          SAMPLES_PER_PKT = 1023,
  parameter logic [15:0] MAGIC           = 16'hADC8
) (
  input  logic                  data_clk,
  input  logic                  dma_rst,
  input  logic                  dma_ena,
  input  logic                  new_sample,
  input  logic [127:0]          adc_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [15:0]           overflow_cnt,
  output logic                  pkt_active
);

  typedef enum logic [1:0] {IDLE, HEADER, LO, HI} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t        state, state_nx;
  logic          accept;
  logic          vld_p0;
  logic [127:0]  data_p0;
  logic [31:0]   ts_p0;
  logic [31:0]   ts_cnt;

  logic [127:0]  buf_data [2];
  logic [31:0]   buf_ts   [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    count;
  logic          push, pop, drop;

  logic [14:0]   pkt_cnt;
  logic [14:0]   sample_idx;
  logic          ovf_flag;
  logic          hs, hdr_hs, last_sample;
  logic          tvalid_nx, tlast_nx;
  logic [DATA_WIDTH-1:0] tdata_nx;
  logic [127:0]  head_data;
  logic [31:0]   head_ts;

  assign pkt_active   = (state != IDLE);
  assign accept       = dma_ena || pkt_active;
  assign m_axis_tkeep = {KEEP_WIDTH{1'b1}};

  // Stage p0: capture the strobed sample and its timestamp
  always_ff @(posedge data_clk) begin
    if (dma_rst) begin
      vld_p0 <= 1'b0;
      ts_cnt <= '0;
    end else begin
      vld_p0 <= new_sample && accept;
      if (new_sample && accept)
        ts_cnt <= ts_cnt + 32'd1;
      else if (!dma_ena && state == IDLE)
        ts_cnt <= '0;
    end
  end

  always_ff @(posedge data_clk) begin
    data_p0 <= adc_data;
    ts_p0   <= ts_cnt;
  end

  // Stage p1: sample buffer; a pop in the same cycle frees the slot being written
  assign push = vld_p0 && (count != 2'd2 || pop);
  assign drop = vld_p0 && count == 2'd2 && !pop;

  always_ff @(posedge data_clk) begin
    if (dma_rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge data_clk) begin
    if (push) begin
      buf_data[wr_ptr] <= data_p0;
      buf_ts[wr_ptr]   <= ts_p0;
    end
  end

  assign head_data   = buf_data[rd_ptr];
  assign head_ts     = buf_ts[rd_ptr];
  assign hs          = m_axis_tvalid && m_axis_tready;
  assign last_sample = (sample_idx == 15'(SAMPLES_PER_PKT - 1));

  // Output registers only change when empty or on a handshake, keeping stalls stable
  always_comb begin
    state_nx  = state;
    tvalid_nx = m_axis_tvalid;
    tlast_nx  = m_axis_tlast;
    tdata_nx  = m_axis_tdata;
    pop       = 1'b0;
    hdr_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (dma_ena && count != 2'd0) begin
          state_nx  = HEADER;
          tvalid_nx = 1'b1;
          tlast_nx  = 1'b0;
          tdata_nx  = {MAGIC, ovf_flag, pkt_cnt, head_ts};
        end
      end
      HEADER: begin
        if (hs) begin
          hdr_hs   = 1'b1;
          state_nx = LO;
          tdata_nx = head_data[63:0];
        end
      end
      LO: begin
        if (hs) begin
          state_nx = HI;
          tdata_nx = head_data[127:64];
          tlast_nx = last_sample;
        end else if (!m_axis_tvalid && count != 2'd0) begin
          tvalid_nx = 1'b1;
          tdata_nx  = head_data[63:0];
        end
      end
      HI: begin
        if (hs) begin
          pop       = 1'b1;
          tvalid_nx = 1'b0;
          tlast_nx  = 1'b0;
          state_nx  = last_sample ? IDLE : LO;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p2: registered stream outputs and packet bookkeeping
  always_ff @(posedge data_clk) begin
    if (dma_rst) begin
      state         <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      pkt_cnt       <= '0;
      sample_idx    <= '0;
      ovf_flag      <= 1'b0;
      overflow_cnt  <= '0;
    end else begin
      state         <= state_nx;
      m_axis_tvalid <= tvalid_nx;
      m_axis_tlast  <= tlast_nx;
      m_axis_tdata  <= tdata_nx;
      if (hdr_hs) pkt_cnt <= pkt_cnt + 15'd1;
      if (pop) sample_idx <= last_sample ? 15'd0 : sample_idx + 15'd1;
      ovf_flag <= drop || (ovf_flag && !hdr_hs);
      if (drop) overflow_cnt <= sat_inc16(overflow_cnt);
    end
  end

endmodule
